// File: rtl/fifo_serializer_chk.sv
// fifo_serializer_chk
//   Property checker bound into every fifo_serializer instance.
//   Elaboration: RATIO >= 2, OUT_WIDTH >= 1.
//   Run time: a stalled beat holds its data and valid; pop never hits an
//   empty FIFO.
//
// Ports (all inputs, mirrored from the serializer)
//   clk_i, rst_ni, clr_i, fifo_empty_i, fifo_pop_o, valid_o, ready_i, data_o
module fifo_serializer_chk #(
    parameter int OUT_WIDTH = 8,
    parameter int RATIO     = 4
) (
    input logic                 clk_i,
    input logic                 rst_ni,
    input logic                 clr_i,
    input logic                 fifo_empty_i,
    input logic                 fifo_pop_o,
    input logic                 valid_o,
    input logic                 ready_i,
    input logic [OUT_WIDTH-1:0] data_o
);

    if (RATIO < 2) begin : g_bad_ratio
        $error("fifo_serializer: RATIO must be at least 2");
    end

    if (OUT_WIDTH < 1) begin : g_bad_width
        $error("fifo_serializer: OUT_WIDTH must be at least 1");
    end

    // A clear legitimately drops a stalled beat, so it is excluded here.
    a_stall_stable : assert property (
        @(posedge clk_i) disable iff (!rst_ni)
        (valid_o && !ready_i && !clr_i) |=> ($stable(data_o) && valid_o)
    );

    a_no_pop_when_empty : assert property (
        @(posedge clk_i) fifo_pop_o |-> !fifo_empty_i
    );

endmodule

bind fifo_serializer fifo_serializer_chk #(
    .OUT_WIDTH (OUT_WIDTH),
    .RATIO     (RATIO)
) u_chk (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .clr_i        (clr_i),
    .fifo_empty_i (fifo_empty_i),
    .fifo_pop_o   (fifo_pop_o),
    .valid_o      (valid_o),
    .ready_i      (ready_i),
    .data_o       (data_o)
);

// File: rtl/fifo_serializer.sv
// fifo_serializer
//   Drains a synchronous FIFO one wide word at a time and replays each word as
//   RATIO narrow beats on a valid/ready stream. The word is copied into a local
//   register on pop, so the FIFO is popped exactly once per word regardless of
//   downstream back-pressure. Consecutive words stream without a bubble.
//
// Ports
//   clk_i         clock
//   rst_ni        asynchronous active-low reset
//   clr_i         synchronous clear, discards any partially sent word
//   fifo_empty_i  FIFO empty flag
//   fifo_data_i   FIFO head word (IN_WIDTH)
//   fifo_pop_o    pop FIFO head (combinational from empty/ready/clr)
//   valid_o       output beat valid
//   ready_i       downstream accepts beat
//   data_o        output beat (OUT_WIDTH)
//   last_o        final beat of the current word
//   busy_o        word register holds an unfinished word
module fifo_serializer #(
    parameter int OUT_WIDTH = 8,
    parameter int RATIO     = 4,
    parameter bit MSB_FIRST = 1'b0,
    parameter int IN_WIDTH  = OUT_WIDTH * RATIO
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 clr_i,
    input  logic                 fifo_empty_i,
    input  logic [IN_WIDTH-1:0]  fifo_data_i,
    output logic                 fifo_pop_o,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic [OUT_WIDTH-1:0] data_o,
    output logic                 last_o,
    output logic                 busy_o
);

    localparam int               CNT_W    = $clog2(RATIO);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RATIO - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_e;

    state_e               state_r;
    logic [CNT_W-1:0]     cnt_r;
    logic [IN_WIDTH-1:0]  word_r;

    logic                 send_s;
    logic                 hs_s;
    logic                 at_last_s;
    logic                 load_s;
    logic [CNT_W-1:0]     sel_s;

    // Handshake, load decision and FIFO pop; pop is masked by clear so a word
    // is never taken from the FIFO in a cycle whose capture is discarded.
    always_comb begin
        send_s     = (state_r == ST_SEND);
        hs_s       = send_s & ready_i;
        at_last_s  = (cnt_r == CNT_LAST);
        load_s     = ~fifo_empty_i & (~send_s | (hs_s & at_last_s));
        fifo_pop_o = load_s & ~clr_i;
    end

    // Slice select; in IDLE the mux parks on slice 0 so data_o stays quiet.
    always_comb begin
        sel_s = CNT_W'(0);
        if (!send_s) begin
            sel_s = CNT_W'(0);
        end else if (MSB_FIRST) begin
            sel_s = CNT_LAST - cnt_r;
        end else begin
            sel_s = cnt_r;
        end
    end

    // Output decode; every output depends on registers only (no ready_i path).
    always_comb begin
        valid_o = send_s;
        busy_o  = send_s;
        last_o  = send_s & at_last_s;
        data_o  = word_r[sel_s*OUT_WIDTH +: OUT_WIDTH];
    end

    // State, beat counter and word register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r <= ST_IDLE;
            cnt_r   <= CNT_W'(0);
            word_r  <= '0;
        end else if (clr_i) begin
            state_r <= ST_IDLE;
            cnt_r   <= CNT_W'(0);
            word_r  <= '0;
        end else if (load_s) begin
            // Covers both the first word from IDLE and the seamless follow-on
            // word taken on the final-beat handshake.
            state_r <= ST_SEND;
            cnt_r   <= CNT_W'(0);
            word_r  <= fifo_data_i;
        end else if (hs_s) begin
            if (at_last_s) begin
                state_r <= ST_IDLE;
                cnt_r   <= CNT_W'(0);
            end else begin
                cnt_r   <= cnt_r + CNT_W'(1);
            end
        end else begin
            state_r <= state_r;
            cnt_r   <= cnt_r;
            word_r  <= word_r;
        end
    end

endmodule

// File: tb/tb_fifo_serializer.sv
// tb_fifo_serializer
//   Directed bench: two serializers (LSB-first and MSB-first) share one FIFO
//   model and one stream of inputs; every beat is checked on both.
module tb_fifo_serializer;

    logic        clk_s   = 1'b0;
    logic        rst_n_s = 1'b1;
    logic        clr_s   = 1'b0;
    logic        ready_s = 1'b0;
    logic        empty_s = 1'b1;
    logic [31:0] fdata_s = 32'h0;

    logic        pop0_s, valid0_s, last0_s, busy0_s;
    logic        pop1_s, valid1_s, last1_s, busy1_s;
    logic [7:0]  d0_s, d1_s;

    int          nvec = 0;
    int          nerr = 0;
    logic [31:0] q[$];

    always #5 clk_s = ~clk_s;

    fifo_serializer #(.OUT_WIDTH(8), .RATIO(4), .MSB_FIRST(1'b0)) u_lsb (
        .clk_i(clk_s), .rst_ni(rst_n_s), .clr_i(clr_s),
        .fifo_empty_i(empty_s), .fifo_data_i(fdata_s), .fifo_pop_o(pop0_s),
        .valid_o(valid0_s), .ready_i(ready_s), .data_o(d0_s),
        .last_o(last0_s), .busy_o(busy0_s)
    );

    fifo_serializer #(.OUT_WIDTH(8), .RATIO(4), .MSB_FIRST(1'b1)) u_msb (
        .clk_i(clk_s), .rst_ni(rst_n_s), .clr_i(clr_s),
        .fifo_empty_i(empty_s), .fifo_data_i(fdata_s), .fifo_pop_o(pop1_s),
        .valid_o(valid1_s), .ready_i(ready_s), .data_o(d1_s),
        .last_o(last1_s), .busy_o(busy1_s)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic refresh();
        empty_s = (q.size() == 0);
        fdata_s = (q.size() == 0) ? 32'h0 : q[0];
    endtask

    // Advance one clock; the FIFO model pops if the LSB-first DUT asked to.
    task automatic cycle();
        logic p;
        p = pop0_s;
        @(posedge clk_s);
        if (p === 1'b1 && q.size() > 0) void'(q.pop_front());
        #1;
        refresh();
    endtask

    task automatic check_out(input string tag, input logic v, input logic l, input logic b,
                             input logic [7:0] e0, input logic [7:0] e1, input logic p);
        chk({tag, ".valid_lsb"}, valid0_s, v);
        chk({tag, ".valid_msb"}, valid1_s, v);
        chk({tag, ".last_lsb"},  last0_s,  l);
        chk({tag, ".last_msb"},  last1_s,  l);
        chk({tag, ".busy_lsb"},  busy0_s,  b);
        chk({tag, ".busy_msb"},  busy1_s,  b);
        chk({tag, ".data_lsb"},  d0_s,     e0);
        chk({tag, ".data_msb"},  d1_s,     e1);
        chk({tag, ".pop_lsb"},   pop0_s,   p);
        chk({tag, ".pop_msb"},   pop1_s,   p);
    endtask

    // IDLE with a word queued: pop now, first beat next cycle.
    task automatic idle_pop(input string tag, input logic [7:0] idle_data);
        ready_s = 1'b1;
        #1;
        check_out(tag, 1'b0, 1'b0, 1'b0, idle_data, idle_data, 1'b1);
        cycle();
    endtask

    // Four beats of one word with ready held high.
    task automatic send_word(input string tag, input logic [31:0] w, input logic pop_at_last);
        for (int b = 0; b < 4; b++) begin
            ready_s = 1'b1;
            #1;
            check_out(tag, 1'b1, (b == 3), 1'b1, w[8*b +: 8], w[8*(3-b) +: 8],
                      (b == 3) && pop_at_last);
            cycle();
        end
    endtask

    logic [63:0] rdy_pat = 64'hA5C3_3C96_5A0F_F0E1;

    initial begin
        int          nb;
        int          k;
        logic [31:0] w;

        // Reset state
        refresh();
        #1;
        rst_n_s = 1'b0;
        #1;
        check_out("reset", 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        q.push_back(32'hDDCCBBAA);
        refresh();
        #1;
        chk("reset_pop_follows_empty", pop0_s, 1'b1);
        q.delete();
        refresh();
        @(posedge clk_s);
        #2;
        rst_n_s = 1'b1;

        // Single word: LSB-first AA..DD, MSB-first DD..AA
        q.push_back(32'hDDCCBBAA);
        refresh();
        idle_pop("t1_load", 8'h00);
        ready_s = 1'b1; #1; check_out("t1_b0", 1'b1, 1'b0, 1'b1, 8'hAA, 8'hDD, 1'b0); cycle();
        ready_s = 1'b1; #1; check_out("t1_b1", 1'b1, 1'b0, 1'b1, 8'hBB, 8'hCC, 1'b0); cycle();
        ready_s = 1'b1; #1; check_out("t1_b2", 1'b1, 1'b0, 1'b1, 8'hCC, 8'hBB, 1'b0); cycle();
        ready_s = 1'b1; #1; check_out("t1_b3", 1'b1, 1'b1, 1'b1, 8'hDD, 8'hAA, 1'b0); cycle();
        #1;
        check_out("t1_idle", 1'b0, 1'b0, 1'b0, 8'hAA, 8'hAA, 1'b0);

        // Back-to-back: pops at 0,4,8 and last at 4,8,12, no bubble
        q.push_back(32'h44332211);
        q.push_back(32'h88776655);
        q.push_back(32'hCCBBAA99);
        refresh();
        idle_pop("t3_load", 8'hAA);
        send_word("t3_w1", 32'h44332211, 1'b1);
        send_word("t3_w2", 32'h88776655, 1'b1);
        send_word("t3_w3", 32'hCCBBAA99, 1'b0);
        #1;
        check_out("t3_idle", 1'b0, 1'b0, 1'b0, 8'h99, 8'h99, 1'b0);

        // Back-pressure: stalls hold data, pop only on the last-beat handshake
        q.push_back(32'hF3F2F1F0);
        q.push_back(32'h0F0E0D0C);
        refresh();
        idle_pop("t4_load", 8'h99);
        nb = 0;
        for (int c = 0; c < 64 && nb < 8; c++) begin
            w = (nb < 4) ? 32'hF3F2F1F0 : 32'h0F0E0D0C;
            k = nb % 4;
            ready_s = rdy_pat[c];
            #1;
            check_out("t4_beat", 1'b1, (k == 3), 1'b1, w[8*k +: 8], w[8*(3-k) +: 8],
                      ready_s && (nb == 3));
            cycle();
            if (ready_s) nb++;
        end
        chk("t4_beats_within_budget", nb, 8);
        #1;
        check_out("t4_idle", 1'b0, 1'b0, 1'b0, 8'h0C, 8'h0C, 1'b0);

        // Clear after BB accepted: word dropped, next word starts at beat 0
        q.push_back(32'hDDCCBBAA);
        q.push_back(32'h77665544);
        refresh();
        idle_pop("t5_load", 8'h0C);
        ready_s = 1'b1; #1; check_out("t5_b0", 1'b1, 1'b0, 1'b1, 8'hAA, 8'hDD, 1'b0); cycle();
        ready_s = 1'b1; #1; check_out("t5_b1", 1'b1, 1'b0, 1'b1, 8'hBB, 8'hCC, 1'b0); cycle();
        clr_s = 1'b1; ready_s = 1'b0;
        #1;
        check_out("t5_clr_cycle", 1'b1, 1'b0, 1'b1, 8'hCC, 8'hBB, 1'b0);
        cycle();
        #1;
        check_out("t5_clr_idle_masked", 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        cycle();
        clr_s = 1'b0;
        idle_pop("t5_reload", 8'h00);
        send_word("t5_w7", 32'h77665544, 1'b0);
        #1;
        check_out("t5_idle", 1'b0, 1'b0, 1'b0, 8'h44, 8'h44, 1'b0);

        // Reset during beat CC: outputs drop at once, remaining words drain
        q.push_back(32'hDDCCBBAA);
        q.push_back(32'h13579BDF);
        q.push_back(32'h2468ACE0);
        refresh();
        idle_pop("t6_load", 8'h44);
        ready_s = 1'b1; #1; check_out("t6_b0", 1'b1, 1'b0, 1'b1, 8'hAA, 8'hDD, 1'b0); cycle();
        ready_s = 1'b1; #1; check_out("t6_b1", 1'b1, 1'b0, 1'b1, 8'hBB, 8'hCC, 1'b0); cycle();
        rst_n_s = 1'b0;
        #1;
        check_out("t6_in_reset", 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
        rst_n_s = 1'b1;
        idle_pop("t6_reload", 8'h00);
        send_word("t6_w9", 32'h13579BDF, 1'b1);
        send_word("t6_w10", 32'h2468ACE0, 1'b0);
        #1;
        check_out("t6_idle", 1'b0, 1'b0, 1'b0, 8'hE0, 8'hE0, 1'b0);
        chk("t6_fifo_drained", q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
